// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by every pipeline stage.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
package regfile_pkg;

    localparam int          REG_BUS       = 32;
    localparam int          REG_ADDR_BUS  = 5;
    localparam int          REG_NUM       = 32;
    localparam logic [31:0] ZERO_WORD     = 32'h0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        READ_ENABLE   = 1'b1;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'b0;

    typedef logic [REG_BUS-1:0]      reg_word_t;
    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_if.sv
// Write port from writeback plus two decode read ports of the register file.
// Build option: REGFILE_BYPASS_EN (see regfile_pkg).
interface regfile_if;
    import regfile_pkg::*;

    logic      we;
    reg_addr_t waddr;
    reg_word_t wdata;
    logic      re1;
    reg_addr_t raddr1;
    reg_word_t rdata1;
    logic      re2;
    reg_addr_t raddr2;
    reg_word_t rdata2;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );

endinterface

// File: rtl/regfile_rport.sv
// One combinational read port; x0, reset and a disabled port all read zero.
// Build option: REGFILE_BYPASS_EN forwards the in-flight write data.
module regfile_rport
    import regfile_pkg::*;
(
    input  logic      rst,
    input  logic      re,
    input  reg_addr_t raddr,
    input  reg_word_t regs [REG_NUM],
`ifdef REGFILE_BYPASS_EN
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_word_t wdata,
`endif
    output reg_word_t rdata
);

    always_comb begin
        rdata = ZERO_WORD;
        if (rst || re != READ_ENABLE || raddr == NOP_REG_ADDR) begin
            rdata = ZERO_WORD;
        end
`ifdef REGFILE_BYPASS_EN
        else if (we == WRITE_ENABLE && raddr == waddr) begin
            rdata = wdata;
        end
`endif
        else begin
            rdata = regs[raddr];
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32 register file: one synchronous write port, two combinational read ports.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding in the read ports.
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    reg_word_t regs_q [REG_NUM];
    reg_word_t regs_d [REG_NUM];

    // Reset wins over a same-edge write; x0 is pinned to zero so reads never see junk.
    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_d[i] = ZERO_WORD;
            end
        end else if (bus.we == WRITE_ENABLE && bus.waddr != NOP_REG_ADDR) begin
            regs_d[bus.waddr] = bus.wdata;
        end
        regs_d[0] = ZERO_WORD;
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    regfile_rport u_rport1 (
        .rst   (rst),
        .re    (bus.re1),
        .raddr (bus.raddr1),
        .regs  (regs_q),
`ifdef REGFILE_BYPASS_EN
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
`endif
        .rdata (bus.rdata1)
    );

    regfile_rport u_rport2 (
        .rst   (rst),
        .re    (bus.re2),
        .raddr (bus.raddr2),
        .regs  (regs_q),
`ifdef REGFILE_BYPASS_EN
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
`endif
        .rdata (bus.rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, a hand sequence and
// randomized traffic against an array-based reference model.
module tb_regfile;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;
    regfile_if bus ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic re,
                                               input logic [4:0] a, input logic w,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (r || !re || a == 5'd0) return 32'h0;
        if (BYPASS && w && wa == a) return wd;
        return model[a];
    endfunction

    task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        rst        = r;
        bus.we     = w;
        bus.waddr  = wa;
        bus.wdata  = wd;
        bus.re1    = e1;
        bus.raddr1 = a1;
        bus.re2    = e2;
        bus.raddr2 = a2;
    endtask

    // Advance through one clock edge, applying the architectural write rules to the model.
    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (bus.we && bus.waddr != 5'd0) begin
            model[bus.waddr] = bus.wdata;
        end
        #1;
    endtask

    task automatic step_model(input string tag);
        logic [31:0] e1, e2;
        @(negedge clk);
        e1 = model_read(rst, bus.re1, bus.raddr1, bus.we, bus.waddr, bus.wdata);
        e2 = model_read(rst, bus.re2, bus.raddr2, bus.we, bus.waddr, bus.wdata);
        check({tag, "_rdata1"}, bus.rdata1, e1);
        check({tag, "_rdata2"}, bus.rdata2, e2);
        clock_edge();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);

        //                 rst   we    waddr  wdata          re1   ra1    re2   ra2    exp1  exp2
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,          1'b1, 5'd5,  1'b1, 5'd7,  32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF,   1'b1, 5'd5,  1'b0, 5'd5,
                     BYPASS ? 32'hDEADBEEF : 32'h0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 32'h0,          1'b1, 5'd5,  1'b1, 5'd5,  32'h0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd5,  1'b1, 5'd5,  32'h0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 5'd7, 32'h12345678,   1'b0, 5'd7,  1'b0, 5'd7,  32'h0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd7,  1'b1, 5'd7,  32'h12345678, 32'h12345678};
        vecs[6]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF,   1'b1, 5'd0,  1'b0, 5'd0,  32'h0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 5'd3, 32'h11,         1'b0, 5'd0,  1'b0, 5'd0,  32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 5'd3, 32'h22,         1'b1, 5'd7,  1'b1, 5'd3,
                     32'h12345678, BYPASS ? 32'h22 : 32'h11};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd3,  1'b1, 5'd3,  32'h22, 32'h22};
        vecs[11] = '{1'b0, 1'b1, 5'd9, 32'hA5A5A5A5,   1'b0, 5'd0,  1'b0, 5'd0,  32'h0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 5'd9,  1'b1, 5'd9,  32'h0, 32'hA5A5A5A5};
        vecs[13] = '{1'b1, 1'b1, 5'd4, 32'h77,         1'b1, 5'd4,  1'b1, 5'd9,  32'h0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd4,  1'b1, 5'd9,  32'h0, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 5'd0, 32'h0,          1'b1, 5'd0,  1'b1, 5'd3,  32'h0, 32'h0};

        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
            @(negedge clk);
            check($sformatf("vec%0d_rdata1", i), bus.rdata1, vecs[i].exp1);
            check($sformatf("vec%0d_rdata2", i), bus.rdata2, vecs[i].exp2);
            clock_edge();
        end

        // Back-to-back writes to one register: the last one must stick.
        drive(1'b0, 1'b1, 5'd12, 32'h0000_00AA, 1'b0, 5'd0, 1'b0, 5'd0);
        clock_edge();
        drive(1'b0, 1'b1, 5'd12, 32'h0000_00BB, 1'b1, 5'd12, 1'b0, 5'd0);
        @(negedge clk);
        check("b2b_mid", bus.rdata1, BYPASS ? 32'h0000_00BB : 32'h0000_00AA);
        clock_edge();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd12);
        @(negedge clk);
        check("b2b_final1", bus.rdata1, 32'h0000_00BB);
        check("b2b_final2", bus.rdata2, 32'h0000_00BB);
        clock_edge();

        for (int n = 0; n < 600; n++) begin
            logic [4:0] wa, a1, a2;
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 31) == 0), 1'($urandom), wa, $urandom,
                  ($urandom_range(0, 3) != 0), a1, ($urandom_range(0, 3) != 0), a2);
            step_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
